// File: rtl/acc_input_buffer_if.sv
// Word stream bundle: DMA push side (in_*) and accelerator valid/ready side (ss_*).
// master = the environment around the buffer, slave = the buffer itself.
interface acc_input_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  ss_tvalid;
    logic [DATA_WIDTH-1:0] ss_tdata;
    logic                  ss_tlast;
    logic                  ss_tready;

    modport master (
        output in_valid, in_data, ss_tready,
        input  ss_tvalid, ss_tdata, ss_tlast
    );

    modport slave (
        input  in_valid, in_data, ss_tready,
        output ss_tvalid, ss_tdata, ss_tlast
    );
endinterface

// File: rtl/acc_input_buffer.sv
// DMA-to-accelerator staging FIFO with tlast framing from a programmed length and overflow reporting.
// Define ACC_IBUF_DROP_CNT_EN to add the saturating drop_cnt_o[15:0] output.
module acc_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int LEN_W      = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    acc_input_buffer_if.slave      bus,
    input  logic                   cfg_len_vld,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   almost_full_o,
    output logic                   ovf_o,
    input  logic                   ovf_clr_i,
`ifdef ACC_IBUF_DROP_CNT_EN
    output logic [15:0]            drop_cnt_o,
`endif
    output logic                   frame_done_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]  LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_AF   = LVL_W'(DEPTH - 2);
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]      level_r, level_nxt_s;
    logic                  tvalid_r, almost_full_r, ovf_r, frame_done_r;
    logic [LEN_W-1:0]      cnt_r, len_r, pend_len_r, len_m1_s;
    logic                  pend_vld_r;
    state_t                state_r, state_nxt_s;
    logic                  run_s;
    logic                  push_s, beat_s, full_s, push_ok_s, drop_s, tlast_s, tlast_beat_s;

    assign push_s       = bus.in_valid & ~flush_i;
    assign beat_s       = tvalid_r & bus.ss_tready;
    assign full_s       = (level_r == LVL_FULL);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s    = push_s & (~full_s | beat_s);
    assign drop_s       = push_s & full_s & ~beat_s;
    assign len_m1_s     = len_r - LEN_ONE;
    assign tlast_s      = tvalid_r & (cnt_r == len_m1_s);
    assign tlast_beat_s = beat_s & tlast_s;

    // Occupancy after this cycle's push/pop, or empty on flush.
    always_comb begin
        level_nxt_s = level_r;
        if (flush_i) begin
            level_nxt_s = LVL_ZERO;
        end else begin
            case ({push_ok_s, beat_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointers, level and the registered status flags derived from it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            level_r       <= LVL_ZERO;
            tvalid_r      <= 1'b0;
            almost_full_r <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (beat_s)    rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r       <= level_nxt_s;
            tvalid_r      <= (level_nxt_s != LVL_ZERO);
            almost_full_r <= (level_nxt_s >= LVL_AF);
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // FSM next state: active from the first accepted word until a frame end drains the FIFO.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = push_ok_s ? ST_RUN : ST_IDLE;
                ST_RUN:  state_nxt_s = (tlast_beat_s && (level_nxt_s == LVL_ZERO)) ? ST_IDLE : ST_RUN;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            ST_RUN:  run_s = 1'b1;
            ST_IDLE: run_s = 1'b0;
            default: run_s = 1'b0;
        endcase
    end

    // Beat counter and frame length; a length written mid-frame waits for the frame boundary.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_r        <= LEN_ZERO;
            len_r        <= LEN_ZERO;
            pend_len_r   <= LEN_ZERO;
            pend_vld_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= tlast_beat_s & ~flush_i;
            if (flush_i) begin
                cnt_r      <= LEN_ZERO;
                pend_vld_r <= 1'b0;
                if (cfg_len_vld) len_r <= cfg_len;
            end else begin
                if (tlast_beat_s)         cnt_r <= LEN_ZERO;
                else if (beat_s && run_s) cnt_r <= cnt_r + LEN_ONE;

                if (cfg_len_vld && ((cnt_r == LEN_ZERO) || tlast_beat_s)) begin
                    len_r      <= cfg_len;
                    pend_vld_r <= 1'b0;
                end else if (cfg_len_vld) begin
                    pend_len_r <= cfg_len;
                    pend_vld_r <= 1'b1;
                end else if (tlast_beat_s && pend_vld_r) begin
                    len_r      <= pend_len_r;
                    pend_vld_r <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)       ovf_r <= 1'b0;
        else if (drop_s)    ovf_r <= 1'b1;
        else if (ovf_clr_i) ovf_r <= 1'b0;
    end

`ifdef ACC_IBUF_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of dropped words; here the clear wins over a simultaneous drop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                                drop_cnt_r <= 16'h0000;
        else if (ovf_clr_i)                          drop_cnt_r <= 16'h0000;
        else if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
    end

    assign drop_cnt_o = drop_cnt_r;
`endif

    assign bus.ss_tvalid = tvalid_r;
    assign bus.ss_tdata  = tvalid_r ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign bus.ss_tlast  = tlast_s;
    assign level_o       = level_r;
    assign almost_full_o = almost_full_r;
    assign ovf_o         = ovf_r;
    assign frame_done_o  = frame_done_r;
endmodule
